audio_out_stream: RTL and testbench
===================================

Name: audio_out_stream

Overview:
- Multi-channel, parametrised successor to the single-channel 8-bit PWM DAC.
- Accepts framed samples (one sample per channel) over a valid/ready stream and buffers them in a frame FIFO.
- Releases one frame per programmable sample-rate tick and drives one 1-bit analog output per channel.
- Each output is generated by a runtime-selectable PWM or first-order sigma-delta modulator; sits between the SPI/SD data path and the output pins.

Parameters:
- NCH, 2, number of channels.
- SW, 8, sample width in bits; samples are unsigned offset-binary.
- FIFO_DEPTH, 16, frame FIFO depth; must be a power of 2.
- DIV_W, 16, width of the sample-rate divider.

Ports:
- clk  in  1  system clock.
- rstn_async  in  1  reset, asynchronous assert, active-low.
- s_valid  in  1  input frame valid.
- s_ready  out  1  FIFO can accept a frame.
- s_data  in  NCH*SW  input frame; channel i is in s_data[i*SW +: SW].
- enable  in  1  playback enable.
- mode  in  1  modulator select: 0 = PWM, 1 = sigma-delta.
- rate_div  in  DIV_W  sample period in clk cycles, minus 1.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  frames currently stored.
- underrun  out  1  one-cycle pulse when a tick finds the FIFO empty.
- underrun_cnt  out  16  saturating count of underruns.
- analog  out  NCH  modulator outputs, registered.

Behaviour:
- Reset state (async, rstn_async low):
  - s_ready=0, analog=0, fifo_level=0, underrun=0, underrun_cnt=0.
  - Hold registers = 2^(SW-1); PWM counter=0; accumulators=0; divider=0.
  - s_ready goes to 1 on the first clk edge after release.
- Push:
  - A frame is pushed on s_valid && s_ready.
  - s_ready = (fifo_level < FIFO_DEPTH), registered. There is no combinational path from pop to s_ready: when full, a same-cycle pop does not allow a push.
- Divider:
  - While enable=1, counts 0..rate_div. tick=1 when count >= rate_div, and count then returns to 0.
  - If rate_div is lowered below the current count, the next cycle ticks.
  - enable=0: count held at 0, no ticks, analog forced to 0. The FIFO still accepts pushes and the hold registers are retained.
- Pop:
  - At tick with fifo_level>0, the head frame is popped and hold[i] updates at tick+1; analog reflects the new value from tick+2.
  - At tick with the FIFO empty: hold registers keep their last value, underrun pulses at tick+1, and underrun_cnt increments, saturating at 0xFFFF.
  - Push and pop in the same cycle: fifo_level unchanged.
  - Empty plus a same-cycle push and tick: counts as an underrun; the pushed frame is stored, with no bypass.
- PWM (mode=0):
  - Shared SW-bit counter c free-runs and wraps at 2^SW-1 -> 0.
  - analog[i] <= (c < hold[i]). A value of 0 gives constant 0; 2^SW-1 gives high for 2^SW-1 of every 2^SW cycles.
- Sigma-delta (mode=1):
  - Per-channel acc[i] is SW+1 bits: acc <= {1'b0, acc[SW-1:0]} + hold[i]; analog[i] <= acc[SW] (carry).
- Mode switch: takes effect on the next clk. Counters and accumulators are not cleared; one transitional period of glitch is permitted.
- FIFO pointers wrap modulo FIFO_DEPTH.

Optional Feature:
- Macro: AUDIO_OUT_VOLUME_EN.
- Defined: adds input vol_shift[2:0]. The modulator input becomes hold[i] >> vol_shift, which attenuates toward 0; vol_shift is sampled each clk.
- Undefined: the port is absent and the modulator input is hold[i] unchanged.

Decomposition:
- Shared package holds:
  - Mode constants MODE_PWM=1'b0 and MODE_SD=1'b1.
  - Hold-register reset value MIDSCALE=2^(SW-1).
  - The underrun counter width, 16.
- Sub-module dac_mod_chan is a single-channel modulator:
  - Inputs: clk, rstn_async, mode, value[SW], shared PWM count[SW], en. Output: analog.
  - Instantiated NCH times via generate.
- The FIFO and divider stay inline.

Test Plan:
1. Reset: hold rstn_async low 5 cycles, then release -> analog=0, fifo_level=0, underrun_cnt=0, s_ready=1 one cycle after release.
2. NCH=2, SW=8, mode=0, rate_div=9: push 30 frames {ch1=0xC0, ch0=0x40}, enable -> once hold is loaded, each 256-cycle window has exactly 64 high cycles on analog[0] and 192 on analog[1].
3. enable=0, push 17 frames back-to-back -> s_ready=0 after the 16th accept, fifo_level=16, the 17th frame is not accepted until a pop.
4. rate_div=3, one frame pushed, enable=1 -> the first tick pops it; the second tick gives an underrun pulse, underrun_cnt=1 and unchanged hold values.
5. mode=1, hold=0x80 -> analog toggles every cycle, exactly 128 highs per 256 cycles; with hold=0x00, analog stays constantly 0.
6. Assert rstn_async asynchronously mid-playback with the FIFO full -> analog=0 and fifo_level=0 immediately, without waiting for a clk edge; after release, hold=0x80 on both channels.

Source files
------------

// File: rtl/audio_out_stream_pkg.sv
// Shared definitions for the multi-channel audio output stream.
//   MODE_PWM / MODE_SD : values of the 1-bit modulator select
//   UNDERRUN_W         : width of the saturating underrun counter
//   midscale(sw)       : hold-register reset value 2^(sw-1) (offset-binary zero)
package audio_out_stream_pkg;

    localparam logic MODE_PWM = 1'b0;
    localparam logic MODE_SD  = 1'b1;

    localparam int unsigned UNDERRUN_W = 16;

    function automatic int unsigned midscale(input int unsigned sw);
        return 32'd1 << (sw - 1);
    endfunction

endpackage

// File: rtl/audio_out_stream_dac_mod_chan.sv
// Single-channel 1-bit modulator (module dac_mod_chan).
//   clk, rstn_async : clock, asynchronous active-low reset
//   mode            : MODE_PWM or MODE_SD, takes effect on the next clk
//   value [SW]      : unsigned sample to modulate
//   count [SW]      : shared free-running PWM counter
//   en              : 0 forces the output low
//   analog          : registered 1-bit output
module dac_mod_chan
    import audio_out_stream_pkg::*;
#(
    parameter int unsigned SW = 8
) (
    input  logic          clk,
    input  logic          rstn_async,
    input  logic          mode,
    input  logic [SW-1:0] value,
    input  logic [SW-1:0] count,
    input  logic          en,
    output logic          analog
);

    // Bit SW of acc is the carry of the previous addition; it is dropped
    // before the next add so the accumulator never overflows.
    logic [SW:0] acc;

    always_ff @(posedge clk or negedge rstn_async) begin
        if (!rstn_async) begin
            acc    <= '0;
            analog <= 1'b0;
        end else begin
            acc <= {1'b0, acc[SW-1:0]} + {1'b0, value};
            if (!en)
                analog <= 1'b0;
            else if (mode == MODE_SD)
                analog <= acc[SW];
            else
                analog <= (count < value);
        end
    end

endmodule

// File: rtl/audio_out_stream.sv
// Multi-channel audio output stream: frame FIFO, sample-rate divider and
// one PWM / sigma-delta modulator per channel.
//   clk, rstn_async  : clock, asynchronous active-low reset
//   s_valid/s_ready  : input frame handshake; s_data holds NCH samples of SW bits
//   enable           : playback enable (0 = no ticks, outputs low)
//   mode             : 0 = PWM, 1 = sigma-delta
//   rate_div         : sample period in clk cycles minus 1
//   fifo_level       : frames stored
//   underrun         : one-cycle pulse when a tick finds the FIFO empty
//   underrun_cnt     : saturating underrun count
//   analog [NCH]     : modulator outputs
// Optional: AUDIO_OUT_VOLUME_EN adds vol_shift[2:0]; modulator input becomes
// hold >> vol_shift.
module audio_out_stream
    import audio_out_stream_pkg::*;
#(
    parameter int unsigned NCH        = 2,
    parameter int unsigned SW         = 8,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned DIV_W      = 16
) (
    input  logic                          clk,
    input  logic                          rstn_async,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [NCH*SW-1:0]             s_data,
    input  logic                          enable,
    input  logic                          mode,
    input  logic [DIV_W-1:0]              rate_div,
`ifdef AUDIO_OUT_VOLUME_EN
    input  logic [2:0]                    vol_shift,
`endif
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          underrun,
    output logic [UNDERRUN_W-1:0]         underrun_cnt,
    output logic [NCH-1:0]                analog
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam logic [LW-1:0] DEPTH_L  = LW'(FIFO_DEPTH);
    localparam logic [SW-1:0] MIDSCALE = SW'(midscale(SW));

    logic [NCH*SW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [LW-1:0]     level_next;
    logic [DIV_W-1:0]  div_cnt;
    logic [SW-1:0]     pwm_cnt;
    logic [SW-1:0]     hold [NCH];
    logic              tick;
    logic              push;
    logic              pop;

    // Divider: a lowered rate_div below the running count ticks immediately.
    always_comb begin
        tick = enable && (div_cnt >= rate_div);
        push = s_valid && s_ready;
        pop  = tick && (fifo_level != '0);
    end

    always_comb begin
        level_next = fifo_level;
        if (push && !pop)
            level_next = fifo_level + 1'b1;
        else if (pop && !push)
            level_next = fifo_level - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= s_data;
    end

    // s_ready is computed from the next level so it is a pure register;
    // a pop while full only frees a slot from the following cycle.
    always_ff @(posedge clk or negedge rstn_async) begin
        if (!rstn_async) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            s_ready    <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            fifo_level <= level_next;
            s_ready    <= (level_next < DEPTH_L);
        end
    end

    always_ff @(posedge clk or negedge rstn_async) begin
        if (!rstn_async) begin
            div_cnt <= '0;
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            if (!enable || tick)
                div_cnt <= '0;
            else
                div_cnt <= div_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn_async) begin
        if (!rstn_async) begin
            underrun     <= 1'b0;
            underrun_cnt <= '0;
        end else begin
            underrun <= tick && (fifo_level == '0);
            if (tick && (fifo_level == '0) && (underrun_cnt != '1))
                underrun_cnt <= underrun_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn_async) begin
        if (!rstn_async) begin
            for (int unsigned i = 0; i < NCH; i++)
                hold[i] <= MIDSCALE;
        end else if (pop) begin
            for (int unsigned i = 0; i < NCH; i++)
                hold[i] <= mem[rd_ptr][i*SW +: SW];
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_chan
        logic [SW-1:0] value;

        always_comb begin
`ifdef AUDIO_OUT_VOLUME_EN
            value = hold[g] >> vol_shift;
`else
            value = hold[g];
`endif
        end

        dac_mod_chan #(
            .SW (SW)
        ) u_chan (
            .clk        (clk),
            .rstn_async (rstn_async),
            .mode       (mode),
            .value      (value),
            .count      (pwm_cnt),
            .en         (enable),
            .analog     (analog[g])
        );
    end

endmodule

// File: tb/tb_audio_out_stream.sv
// Directed testbench for audio_out_stream (NCH=2, SW=8, FIFO_DEPTH=16).
// A cycle table covers push/tick/underrun timing; hand-written sequences
// cover duty cycles, FIFO full, sigma-delta and asynchronous reset.
module tb_audio_out_stream;

    logic        clk = 1'b0;
    logic        rstn_async;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] s_data;
    logic        enable;
    logic        mode;
    logic [15:0] rate_div;
    logic [4:0]  fifo_level;
    logic        underrun;
    logic [15:0] underrun_cnt;
    logic [1:0]  analog;
`ifdef AUDIO_OUT_VOLUME_EN
    logic [2:0]  vol_shift = 3'd0;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    audio_out_stream #(
        .NCH        (2),
        .SW         (8),
        .FIFO_DEPTH (16),
        .DIV_W      (16)
    ) dut (
`ifdef AUDIO_OUT_VOLUME_EN
        .vol_shift    (vol_shift),
`endif
        .clk          (clk),
        .rstn_async   (rstn_async),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .enable       (enable),
        .mode         (mode),
        .rate_div     (rate_div),
        .fifo_level   (fifo_level),
        .underrun     (underrun),
        .underrun_cnt (underrun_cnt),
        .analog       (analog)
    );

    typedef struct {
        logic        sv;
        logic [15:0] data;
        logic        en;
        logic        rdy;
        logic [4:0]  lvl;
        logic        und;
        logic [15:0] ucnt;
    } vec_t;

    vec_t tbl [18];

    function automatic vec_t mk(input logic sv, input logic [15:0] d, input logic en,
                                input logic rdy, input logic [4:0] lvl, input logic und,
                                input logic [15:0] uc);
        vec_t v;
        v.sv = sv; v.data = d; v.en = en; v.rdy = rdy; v.lvl = lvl; v.und = und; v.ucnt = uc;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic measure(input int n, output int h0, output int h1, output int u);
        h0 = 0; h1 = 0; u = 0;
        repeat (n) begin
            @(negedge clk);
            h0 += int'(analog[0]);
            h1 += int'(analog[1]);
            u  += int'(underrun);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int h0, h1, u, tog;
        logic prev;
        bit found;

        // Cycle table, rate_div=3, mode=PWM. Row: inputs applied at negedge,
        // outputs expected at the next negedge.
        tbl[0]  = mk(1, 16'h1122, 0, 1, 1, 0, 0);  // push while disabled
        tbl[1]  = mk(0, 16'h0000, 1, 1, 1, 0, 0);  // count 0->1
        tbl[2]  = mk(0, 16'h0000, 1, 1, 1, 0, 0);
        tbl[3]  = mk(0, 16'h0000, 1, 1, 1, 0, 0);
        tbl[4]  = mk(0, 16'h0000, 1, 1, 0, 0, 0);  // tick pops
        tbl[5]  = mk(0, 16'h0000, 1, 1, 0, 0, 0);
        tbl[6]  = mk(0, 16'h0000, 1, 1, 0, 0, 0);
        tbl[7]  = mk(0, 16'h0000, 1, 1, 0, 0, 0);
        tbl[8]  = mk(0, 16'h0000, 1, 1, 0, 1, 1);  // tick on empty
        tbl[9]  = mk(0, 16'h0000, 1, 1, 0, 0, 1);
        tbl[10] = mk(0, 16'h0000, 1, 1, 0, 0, 1);
        tbl[11] = mk(0, 16'h0000, 1, 1, 0, 0, 1);
        tbl[12] = mk(1, 16'h3344, 1, 1, 1, 1, 2);  // empty + push + tick
        tbl[13] = mk(0, 16'h0000, 1, 1, 1, 0, 2);
        tbl[14] = mk(0, 16'h0000, 1, 1, 1, 0, 2);
        tbl[15] = mk(0, 16'h0000, 1, 1, 1, 0, 2);
        tbl[16] = mk(1, 16'h5566, 1, 1, 1, 0, 2);  // push + pop same cycle
        tbl[17] = mk(0, 16'h0000, 1, 1, 1, 0, 2);

        rstn_async = 1'b0; s_valid = 1'b0; s_data = '0;
        enable = 1'b0; mode = 1'b0; rate_div = 16'd3;

        // Reset
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rst_analog", analog, 0);
        check("rst_level", fifo_level, 0);
        check("rst_ucnt", underrun_cnt, 0);
        check("rst_underrun", underrun, 0);
        check("rst_ready", s_ready, 0);
        rstn_async = 1'b1;
        #1 check("ready_before_edge", s_ready, 0);
        @(negedge clk);
        check("ready_after_release", s_ready, 1);

        for (int i = 0; i < 18; i++) begin
            s_valid = tbl[i].sv;
            s_data  = tbl[i].data;
            enable  = tbl[i].en;
            @(negedge clk);
            check($sformatf("row%0d_ready", i), s_ready, tbl[i].rdy);
            check($sformatf("row%0d_level", i), fifo_level, tbl[i].lvl);
            check($sformatf("row%0d_underrun", i), underrun, tbl[i].und);
            check($sformatf("row%0d_ucnt", i), underrun_cnt, tbl[i].ucnt);
        end
        s_valid = 1'b0;

        // Hold = 0x44/0x33, no ticks for the window
        rate_div = 16'hFFFF;
        measure(256, h0, h1, u);
        check("pwm44_ch0", h0, 68);
        check("pwm33_ch1", h1, 51);
        check("pwm44_underruns", u, 0);

        // Lowering rate_div below the count ticks on the next cycle
        rate_div = 16'd3;
        @(negedge clk);
        check("lowered_rate_pop_level", fifo_level, 0);
        check("lowered_rate_underrun", underrun, 0);
        repeat (3) @(negedge clk);
        check("pre_underrun", underrun, 0);
        @(negedge clk);
        check("underrun_pulse", underrun, 1);
        check("underrun_cnt3", underrun_cnt, 3);
        // Hold 0x66/0x55 must survive repeated underruns
        measure(256, h0, h1, u);
        check("hold66_ch0", h0, 102);
        check("hold55_ch1", h1, 85);
        check("underruns_per_256", u, 64);

        // Fill the FIFO while disabled
        enable = 1'b0; s_valid = 1'b1; s_data = 16'hC040;
        repeat (16) @(negedge clk);
        check("full_level", fifo_level, 16);
        check("full_ready", s_ready, 0);
        repeat (3) @(negedge clk);
        check("full_hold_level", fifo_level, 16);
        enable = 1'b1; rate_div = 16'd9;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk);
            if (fifo_level != 5'd16) found = 1'b1;
        end
        check("pop_seen", found, 1);
        check("after_pop_level", fifo_level, 15);
        check("after_pop_ready", s_ready, 1);
        @(negedge clk);
        check("17th_accept_level", fifo_level, 16);
        check("17th_accept_ready", s_ready, 0);
        s_valid = 1'b0;

        // PWM duty 0x40/0xC0
        repeat (2) @(negedge clk);
        measure(256, h0, h1, u);
        check("pwm40_ch0", h0, 64);
        check("pwmC0_ch1", h1, 192);

        // Refill, then sigma-delta on 0x40/0xC0 with no ticks
        enable = 1'b0; s_valid = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (!s_ready) found = 1'b1;
        end
        s_valid = 1'b0;
        check("refill_done", found, 1);
        check("refill_level", fifo_level, 16);
        enable = 1'b1; mode = 1'b1; rate_div = 16'hFFFF;
        repeat (8) @(negedge clk);
        measure(256, h0, h1, u);
        check("sd40_ch0", h0, 64);
        check("sdC0_ch1", h1, 192);

        // Asynchronous reset between clock edges
        #2 rstn_async = 1'b0;
        #1;
        check("async_analog", analog, 0);
        check("async_level", fifo_level, 0);
        check("async_ready", s_ready, 0);
        check("async_ucnt", underrun_cnt, 0);
        repeat (2) @(negedge clk);
        rstn_async = 1'b1;
        @(negedge clk);
        check("rerelease_ready", s_ready, 1);

        // Sigma-delta on midscale: toggles every cycle
        repeat (2) @(negedge clk);
        prev = analog[0];
        tog = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (analog[0] != prev) tog++;
            prev = analog[0];
        end
        check("sd80_toggles", tog, 16);
        measure(256, h0, h1, u);
        check("sd80_ch0", h0, 128);
        check("sd80_ch1", h1, 128);

        // Zero sample gives a constant 0 in both modes
        rate_div = 16'd3; s_valid = 1'b1; s_data = 16'h0000;
        @(negedge clk);
        s_valid = 1'b0;
        repeat (16) @(negedge clk);
        measure(64, h0, h1, u);
        check("sd00_highs", h0 + h1, 0);
        mode = 1'b0;
        repeat (2) @(negedge clk);
        measure(256, h0, h1, u);
        check("pwm00_highs", h0 + h1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
